// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - access size encodings (SZ_*)
//   - responder FSM state enum
//   - lane_mask(): byte-enable mask for a given size and byte offset
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;   // decoded as a word access

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // One bit per byte lane, little-endian (bit 0 = bits [7:0]).
    // Halfword offset bit 0 is dropped: a misaligned half never writes anyway.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] offset);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << offset;
            SZ_HALF: lane_mask = 4'b0011 << {offset[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   old_word    in  32  current array word at the access index
//   wdata       in  32  right-justified store data
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   offset      in  2   byte offset within the word (addr[1:0])
//   is_unsigned in  1   zero-extend (1) or sign-extend (0) sub-word loads
//   new_word    out 32  old_word with the addressed lanes replaced by wdata
//   load_data   out 32  addressed lane(s) of old_word, extended to 32 bits
//   misaligned  out 1   half at odd address, or word/reserved not word-aligned
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] new_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [3:0]  mask;
    logic [31:0] bit_mask;
    logic [31:0] wrep;
    logic [31:0] shifted;

    assign mask     = lane_mask(size, offset);
    assign bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

    // Replicate the store data across all lanes so the mask alone picks
    // the destination lane; no separate shifter is needed.
    always_comb begin
        case (size)
            SZ_BYTE: wrep = {4{wdata[7:0]}};
            SZ_HALF: wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
    end

    assign new_word = (wrep & bit_mask) | (old_word & ~bit_mask);

    assign shifted = old_word >> {offset, 3'b000};

    always_comb begin
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = old_word;
        endcase
    end

    assign misaligned = ((size == SZ_HALF) && offset[0]) ||
                        (size[1] && (offset != 2'b00));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the memory-stage load/store port.
// Accepts one request at a time, waits LATENCY cycles, performs a
// byte/half/word access on an internal word array, then signals a response.
// Optional macro DMEM_RSP_READY_EN adds rsp_ready backpressure on the response.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_addr                 byte address (upper bits wrap modulo array)
//   req_write                1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 treated as word
//   req_unsigned             zero-extend sub-word loads
//   req_wdata                right-justified store data
//   rsp_ready                (DMEM_RSP_READY_EN only) response accepted
//   rsp_valid                response pulse (held until rsp_ready if enabled)
//   rsp_rdata                extended load data, 0 for stores and errors
//   rsp_err                  misaligned access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
`ifdef DMEM_RSP_READY_EN
    input  logic        rsp_ready,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic [AW+1:0]   a_addr;
    logic            a_write;
    logic [1:0]      a_size;
    logic            a_uns;
    logic [31:0]     a_wdata;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     old_word, new_word, load_data;
    logic            misaligned;
    logic            access;
    logic            accept;

    // Address bits above the array index are deliberately ignored (wrap).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign old_word = mem[a_addr[AW+1:2]];

    dmem_lane_align u_align (
        .old_word    (old_word),
        .wdata       (a_wdata),
        .size        (a_size),
        .offset      (a_addr[1:0]),
        .is_unsigned (a_uns),
        .new_word    (new_word),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
`ifdef DMEM_RSP_READY_EN
                if (rsp_ready) state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            a_addr    <= '0;
            a_write   <= 1'b0;
            a_size    <= SZ_BYTE;
            a_uns     <= 1'b0;
            a_wdata   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                a_addr  <= req_addr[AW+1:0];
                a_write <= req_write;
                a_size  <= req_size;
                a_uns   <= req_unsigned;
                a_wdata <= req_wdata;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // Response registers change only on the access edge, so they
            // stay stable through RESP and until the next access.
            if (access) begin
                rsp_rdata <= (a_write || misaligned) ? 32'd0 : load_data;
                rsp_err   <= misaligned;
            end
        end
    end

    // Array has no reset; a reset in WAIT returns state to IDLE at once,
    // which drops access and so suppresses the write.
    always_ff @(posedge clk) begin
        if (access && a_write && !misaligned)
            mem[a_addr[AW+1:2]] <= new_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_RSP_READY_EN
    logic        rsp_ready = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
`ifdef DMEM_RSP_READY_EN
        .rsp_ready    (rsp_ready),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for its response. lat = edges from the
    // accepting edge to the edge after which rsp_valid is seen (-1 on timeout).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_addr = addr; req_unsigned = uns; req_wdata = wd;
        @(posedge clk); #1;
        // scramble inputs: they must have been captured at acceptance
        req_valid = 1'b0; req_write = ~w; req_size = ~sz;
        req_addr = 32'hFFFF_FFFF; req_unsigned = ~uns; req_wdata = ~wd;
        lat = 0; rd = 32'd0; er = 1'b0;
        while (lat < 40) begin
            @(posedge clk); lat++; #1;
            if (rsp_valid) break;
        end
        if (rsp_valid) begin
            rd = rsp_rdata; er = rsp_err;
        end else begin
            lat = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc, pulses, first_acc, second_acc, cnt_v;
        logic [31:0] last_rd;

        //          w     sz     addr          uns   wdata          exp_rdata      err
        tbl[0]  = '{1'b1, 2'b10, 32'h0000_0010, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 32'h0000_0011, 1'b0, 32'hAAAA_AA80, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'h0,         32'hDEAD_80EF, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 32'h0000_0011, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 32'h0000_0011, 1'b1, 32'h0,         32'h0000_0080, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 32'h0000_0012, 1'b0, 32'h5555_8001, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'h0,         32'h8001_80EF, 1'b0};
        tbl[8]  = '{1'b0, 2'b01, 32'h0000_0012, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0};
        tbl[9]  = '{1'b0, 2'b01, 32'h0000_0012, 1'b1, 32'h0,         32'h0000_8001, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 32'h0000_0013, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'h0,         32'h8001_80EF, 1'b0};
        tbl[12] = '{1'b0, 2'b01, 32'h0000_0011, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        tbl[13] = '{1'b0, 2'b11, 32'h0000_0010, 1'b0, 32'h0,         32'h8001_80EF, 1'b0};
        tbl[14] = '{1'b1, 2'b10, 32'h0000_1010, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'h0,         32'h1234_5678, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 32'h0000_0013, 1'b0, 32'h0,         32'h0000_0012, 1'b0};
        tbl[17] = '{1'b0, 2'b10, 32'h0000_0010, 1'b1, 32'h0,         32'h1234_5678, 1'b0};
        tbl[18] = '{1'b1, 2'b10, 32'h0000_0020, 1'b0, 32'h1111_1111, 32'h0000_0000, 1'b0};
        tbl[19] = '{1'b0, 2'b10, 32'h0000_0020, 1'b0, 32'h0,         32'h1111_1111, 1'b0};

        req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
        reset = 1'b1;
        #2;
        chk("reset_ready",  {31'd0, req_ready}, 32'd1);
        chk("reset_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata",  rsp_rdata,          32'd0);
        chk("reset_err",    {31'd0, rsp_err},   32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].uns, tbl[i].wd, rd, er, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
        end

        // Back-to-back: request held valid, one accept per 4 cycles.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_addr = 32'h0000_0010; req_unsigned = 1'b0; req_wdata = 32'd0;
        acc = 0; pulses = 0; first_acc = -1; second_acc = -1; last_rd = 32'd0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) begin
                if (acc == 0) first_acc = i;
                else if (acc == 1) second_acc = i;
                acc++;
            end
            if (rsp_valid) begin
                pulses++;
                last_rd = rsp_rdata;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts",   32'(acc),                     32'd3);
        chk("b2b_gap",       32'(second_acc - first_acc),  32'd4);
        chk("b2b_pulses",    32'(pulses),                  32'd3);
        chk("b2b_rdata",     last_rd,                      32'h1234_5678);
        chk("resp_exit_idle", {31'd0, req_ready},          32'd1);

        // Reset during WAIT of a store: aborted, no write, no pulse.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h0000_0020; req_unsigned = 1'b0; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("wait_reset_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt_v++;
        end
        chk("wait_reset_no_pulse", 32'(cnt_v), 32'd0);
        do_req(1'b0, 2'b10, 32'h0000_0020, 1'b0, 32'd0, rd, er, lat);
        chk("wait_reset_mem", rd, 32'h1111_1111);

        // Reset during RESP kills the pulse immediately.
        do_req(1'b0, 2'b10, 32'h0000_0010, 1'b0, 32'd0, rd, er, lat);
        chk("pre_resp_reset_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("resp_reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("resp_reset_rdata", rsp_rdata,          32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the memory-stage load/store interface. The memory stage issues requests; this block answers them.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then performs a byte, halfword or word access on an internal word array.
- Returns a single-cycle response pulse carrying load data, sign- or zero-extended, plus a misalignment error flag.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, ≥2).
- LATENCY, 2, wait states between acceptance and access (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  32  byte address.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access; valid with rsp_valid.

Behaviour:
- Clocking and reset: one clock. reset is asynchronous and active-high and clears all registers immediately.
- Reset values:
  - state=IDLE, wait counter=0.
  - req_ready=1 (combinational from IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch addr/write/size/unsigned/wdata, load counter with LATENCY-1, and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter≠0, decrement.
  - If counter=0, perform the access on this edge, register rsp_rdata/rsp_err, and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - rsp_rdata/rsp_err hold their values until the next access edge.
- Timing:
  - Acceptance at edge E0 gives rsp_valid high in the cycle after edge E0+LATENCY.
  - The next acceptance is possible at edge E0+LATENCY+2 at the earliest.
  - Stores also produce a response pulse, with rdata=0.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo the array size.
- Byte lanes are little-endian: byte offset 0 maps to bits [7:0], halfword offset 0 maps to bits [15:0].
- Stores:
  - Only the addressed lanes are modified; the other lanes are preserved by read-modify-write in the access cycle.
  - byte writes wdata[7:0]; half writes wdata[15:0].
- Loads:
  - Extract the addressed lane(s).
  - Extend bit 7 or bit 15 when req_unsigned=0; zero-fill when req_unsigned=1.
  - req_unsigned is ignored for word loads.
- Misalignment:
  - Defined as half with addr[0]=1, or word/reserved with addr[1:0]≠0.
  - Result: no array write, rsp_err=1, rsp_rdata=0, and a normal response pulse.
- Boundary conditions:
  - req_valid while not in IDLE is ignored; the requester must hold it.
  - Request inputs are sampled only at acceptance; later changes have no effect.
  - Reset asserted in WAIT aborts the request with no array write.
  - Reset asserted in RESP kills the pulse immediately.
  - A request arriving on the edge where RESP exits is not accepted; it is accepted on the following edge.

Optional Feature:
- DMEM_RSP_READY_EN defined:
  - Adds input port rsp_ready (1 bit).
  - RESP holds rsp_valid=1 and stable rsp_rdata/rsp_err until an edge with rsp_ready=1, then goes to IDLE.
- Undefined: no port, and the response is the one-cycle pulse described above.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/WAIT/RESP.
  - a function or constant for lane-mask generation.
- One sub-module, dmem_lane_align. It is combinational and contains:
  - a store merge producing (old word, wdata, size, offset) → new word.
  - a load extract producing (word, size, offset, unsigned) → extended data.
  - a misalign detect.

Test Plan:
- Reset with LATENCY=2: req_ready=1, rsp_valid=0. Store word 0xDEADBEEF at 0x10, then load word from 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, with the pulse after edge E0+2.
- Byte store 0x80 at 0x11 over 0xDEADBEEF:
  - word becomes 0xDEAD80EF.
  - signed byte load at 0x11 → 0xFFFFFF80.
  - unsigned byte load at 0x11 → 0x00000080.
- Half store 0x8001 at 0x12 gives word 0x800180EF. A signed half load from 0x12 → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned word store at 0x13 → rsp_err=1, rdata=0; a following load at 0x10 is unchanged (0x800180EF).
- Wrap with DEPTH_WORDS=1024: store 0x12345678 at 0x1010, then load at 0x0010 → 0x12345678. Back-to-back requests held valid → one accept per 4 cycles (LATENCY=2).
- Reset pulse during WAIT of a store 0xFFFFFFFF at 0x20: no rsp_valid, and a subsequent load at 0x20 returns the previous contents.
